split_accept_gate: RTL and testbench

Sequential acceptance stage placed directly downstream of a `split_N` constraint module.
- Takes randomly generated candidate vectors from the upstream generator through a valid/ready handshake.
- Presents each candidate to the split module's packed variable bus and samples its constraint bit `x`.
- Forwards satisfying candidates to the consumer; retries unsatisfying ones up to a bounded count.
- Optionally keeps saturating accept/reject statistics for solver bring-up.

---
 rtl/split_accept_gate.sv | 132 +++++++++++++
 tb/tb_split_accept_gate.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/split_accept_gate.sv
// Acceptance stage behind a split_N constraint module: takes candidates, samples split_x, forwards hits, retries misses.
// Optional saturating accept/reject statistics are built when SPLIT_ACCEPT_GATE_STATS_EN is defined.
module split_accept_gate #(
    parameter int DATA_W    = 1024,
    parameter int MAX_TRIES = 16,
    parameter int CNT_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cand_valid,
    output logic              cand_ready,
    input  logic [DATA_W-1:0] cand_data,
    output logic [DATA_W-1:0] split_bus,
    input  logic              split_x,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_fail,
    output logic [CNT_W-1:0]  acc_cnt,
    output logic [CNT_W-1:0]  rej_cnt
);
    localparam int TRIES_W = $clog2(MAX_TRIES + 1);
    localparam logic [TRIES_W-1:0] TRIES_LAST = TRIES_W'(MAX_TRIES - 1);

    typedef enum logic [1:0] {IDLE, EVAL, OUT} state_t;

    state_t              state_q;
    logic                cand_ready_q;
    logic                out_valid_q;
    logic                out_fail_q;
    logic [DATA_W-1:0]   out_data_q;
    logic [DATA_W-1:0]   eval_q;
    logic [TRIES_W-1:0]  tries_q;

    // cand_ready is registered so it stays low during the first cycle after reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cand_ready_q <= 1'b0;
            out_valid_q  <= 1'b0;
            out_fail_q   <= 1'b0;
            out_data_q   <= '0;
            eval_q       <= '0;
            tries_q      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    cand_ready_q <= 1'b1;
                    if (cand_valid && cand_ready_q) begin
                        eval_q       <= cand_data;
                        cand_ready_q <= 1'b0;
                        state_q      <= EVAL;
                    end
                end
                EVAL: begin
                    if (split_x) begin
                        out_data_q  <= eval_q;
                        out_fail_q  <= 1'b0;
                        out_valid_q <= 1'b1;
                        state_q     <= OUT;
                    end else begin
                        tries_q <= tries_q + TRIES_W'(1);
                        if (tries_q == TRIES_LAST) begin
                            out_data_q  <= eval_q;
                            out_fail_q  <= 1'b1;
                            out_valid_q <= 1'b1;
                            state_q     <= OUT;
                        end else begin
                            cand_ready_q <= 1'b1;
                            state_q      <= IDLE;
                        end
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        tries_q      <= '0;
                        out_valid_q  <= 1'b0;
                        cand_ready_q <= 1'b1;
                        state_q      <= IDLE;
                    end
                end
                default: begin
                    cand_ready_q <= 1'b0;
                    state_q      <= IDLE;
                end
            endcase
        end
    end

    assign cand_ready = cand_ready_q;
    assign split_bus  = eval_q;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_fail   = out_fail_q;

`ifdef SPLIT_ACCEPT_GATE_STATS_EN
    logic [CNT_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] rej_q, rej_d;
    logic             eval_now;

    assign eval_now = (state_q == EVAL);

    // counters stick at all-ones instead of wrapping
    always_comb begin
        acc_d = acc_q;
        rej_d = rej_q;
        if (eval_now && split_x && (acc_q != '1)) begin
            acc_d = acc_q + CNT_W'(1);
        end
        if (eval_now && !split_x && (rej_q != '1)) begin
            rej_d = rej_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
            rej_q <= '0;
        end else begin
            acc_q <= acc_d;
            rej_q <= rej_d;
        end
    end

    assign acc_cnt = acc_q;
    assign rej_cnt = rej_q;
`else
    assign acc_cnt = '0;
    assign rej_cnt = '0;
`endif

endmodule

// File: tb/tb_split_accept_gate.sv
// Bench for split_accept_gate: three instances (MAX_TRIES 16/4/1) share stimulus and are checked every cycle
// against a transaction-level reference, plus a directed vector table and hand-written corner sequences.
module tb_split_accept_gate;
    localparam int DW = 32;
`ifdef SPLIT_ACCEPT_GATE_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic          clk;
    logic          rst;
    logic          cand_valid;
    logic [DW-1:0] cand_data;
    logic          split_x;
    logic          out_ready;

    logic [2:0]    cr, ov, of;
    logic [DW-1:0] od [3];
    logic [DW-1:0] sb [3];
    logic [31:0]   acc_w [3];
    logic [31:0]   rej_w [3];
    logic [31:0]   acc_a, rej_a;
    logic [1:0]    acc_b, rej_b;
    logic [3:0]    acc_c, rej_c;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    split_accept_gate #(.DATA_W(DW), .MAX_TRIES(16), .CNT_W(32)) dut_a (
        .clk(clk), .rst(rst), .cand_valid(cand_valid), .cand_ready(cr[0]), .cand_data(cand_data),
        .split_bus(sb[0]), .split_x(split_x), .out_valid(ov[0]), .out_ready(out_ready),
        .out_data(od[0]), .out_fail(of[0]), .acc_cnt(acc_a), .rej_cnt(rej_a));
    split_accept_gate #(.DATA_W(DW), .MAX_TRIES(4), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .cand_valid(cand_valid), .cand_ready(cr[1]), .cand_data(cand_data),
        .split_bus(sb[1]), .split_x(split_x), .out_valid(ov[1]), .out_ready(out_ready),
        .out_data(od[1]), .out_fail(of[1]), .acc_cnt(acc_b), .rej_cnt(rej_b));
    split_accept_gate #(.DATA_W(DW), .MAX_TRIES(1), .CNT_W(4)) dut_c (
        .clk(clk), .rst(rst), .cand_valid(cand_valid), .cand_ready(cr[2]), .cand_data(cand_data),
        .split_bus(sb[2]), .split_x(split_x), .out_valid(ov[2]), .out_ready(out_ready),
        .out_data(od[2]), .out_fail(of[2]), .acc_cnt(acc_c), .rej_cnt(rej_c));

    assign acc_w[0] = acc_a;
    assign rej_w[0] = rej_a;
    assign acc_w[1] = {30'd0, acc_b};
    assign rej_w[1] = {30'd0, rej_b};
    assign acc_w[2] = {28'd0, acc_c};
    assign rej_w[2] = {28'd0, rej_c};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: a candidate under test, at most one pending result, and a reject tally per result.
    int          mt   [3] = '{16, 4, 1};
    longint      cmax [3] = '{64'd4294967295, 64'd3, 64'd15};
    bit          m_rdy    [3];
    bit          m_held_v [3];
    logic [DW-1:0] m_bus  [3];
    bit          m_res_v  [3];
    logic [DW-1:0] m_res_d [3];
    bit          m_res_f  [3];
    int          m_tries  [3];
    longint      m_acc    [3];
    longint      m_rej    [3];

    task automatic model_step(input int k);
        if (rst) begin
            m_rdy[k] = 0; m_held_v[k] = 0; m_bus[k] = '0; m_res_v[k] = 0;
            m_res_d[k] = '0; m_res_f[k] = 0; m_tries[k] = 0; m_acc[k] = 0; m_rej[k] = 0;
        end else if (m_res_v[k]) begin
            if (out_ready) begin
                m_res_v[k] = 0; m_tries[k] = 0; m_rdy[k] = 1;
            end
        end else if (m_held_v[k]) begin
            m_held_v[k] = 0;
            if (split_x) begin
                if (m_acc[k] < cmax[k]) m_acc[k]++;
                m_res_v[k] = 1; m_res_d[k] = m_bus[k]; m_res_f[k] = 0; m_rdy[k] = 0;
            end else begin
                if (m_rej[k] < cmax[k]) m_rej[k]++;
                m_tries[k]++;
                if (m_tries[k] == mt[k]) begin
                    m_res_v[k] = 1; m_res_d[k] = m_bus[k]; m_res_f[k] = 1; m_rdy[k] = 0;
                end else begin
                    m_rdy[k] = 1;
                end
            end
        end else if (m_rdy[k] && cand_valid) begin
            m_bus[k] = cand_data; m_held_v[k] = 1; m_rdy[k] = 0;
        end else begin
            m_rdy[k] = 1;
        end
    endtask

    task automatic compare_model(input int k);
        logic [31:0] ea, er;
        ea = STATS ? 32'(m_acc[k]) : 32'd0;
        er = STATS ? 32'(m_rej[k]) : 32'd0;
        checks++;
        if ({cr[k], ov[k], of[k]} !== {m_rdy[k], m_res_v[k], m_res_f[k]} || od[k] !== m_res_d[k] ||
            sb[k] !== m_bus[k] || acc_w[k] !== ea || rej_w[k] !== er) begin
            failures++;
            $display("FAIL model[%0d] cyc=%0d got/exp rdy=%b/%b vld=%b/%b fail=%b/%b data=%h/%h bus=%h/%h acc=%0d/%0d rej=%0d/%0d",
                     k, cyc, cr[k], m_rdy[k], ov[k], m_res_v[k], of[k], m_res_f[k], od[k], m_res_d[k],
                     sb[k], m_bus[k], acc_w[k], ea, rej_w[k], er);
        end
    endtask

    task automatic tick();
        for (int k = 0; k < 3; k++) model_step(k);
        @(posedge clk);
        #1;
        cyc++;
        for (int k = 0; k < 3; k++) compare_model(k);
    endtask

    task automatic drive(input bit r, input bit cv, input logic [DW-1:0] cd, input bit sx, input bit ordy);
        rst = r; cand_valid = cv; cand_data = cd; split_x = sx; out_ready = ordy;
        tick();
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, act, exp);
        end
    endtask

    typedef struct {
        bit r, cv; logic [DW-1:0] cd; bit sx, ordy;
        bit e_rdy, e_vld; logic [DW-1:0] e_data; bit e_fail; int e_acc, e_rej;
    } vec_t;

    function automatic vec_t mk(bit r, bit cv, logic [DW-1:0] cd, bit sx, bit ordy,
                                bit e_rdy, bit e_vld, logic [DW-1:0] e_data, bit e_fail, int e_acc, int e_rej);
        vec_t v;
        v.r = r; v.cv = cv; v.cd = cd; v.sx = sx; v.ordy = ordy;
        v.e_rdy = e_rdy; v.e_vld = e_vld; v.e_data = e_data; v.e_fail = e_fail; v.e_acc = e_acc; v.e_rej = e_rej;
        return v;
    endfunction

    vec_t tbl [15];

    initial begin
        logic [DW-1:0] d0;
        rst = 1'b1; cand_valid = 1'b0; cand_data = '0; split_x = 1'b0; out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            m_rdy[k] = 0; m_held_v[k] = 0; m_bus[k] = '0; m_res_v[k] = 0;
            m_res_d[k] = '0; m_res_f[k] = 0; m_tries[k] = 0; m_acc[k] = 0; m_rej[k] = 0;
        end

        //            rst cv cd         sx or   rdy vld data       fail acc rej   (dut_a, MAX_TRIES=16)
        tbl[0]  = mk(1, 0, 32'h0,    0, 0,   0, 0, 32'h0,    0, 0, 0);
        tbl[1]  = mk(1, 0, 32'h0,    0, 0,   0, 0, 32'h0,    0, 0, 0);
        tbl[2]  = mk(0, 0, 32'h0,    0, 0,   1, 0, 32'h0,    0, 0, 0);
        tbl[3]  = mk(0, 1, 32'h5A,   0, 0,   0, 0, 32'h0,    0, 0, 0);
        tbl[4]  = mk(0, 0, 32'h0,    1, 0,   0, 1, 32'h5A,   0, 1, 0);
        tbl[5]  = mk(0, 0, 32'h0,    0, 1,   1, 0, 32'h5A,   0, 1, 0);
        tbl[6]  = mk(0, 1, 32'h11,   0, 0,   0, 0, 32'h5A,   0, 1, 0);
        tbl[7]  = mk(0, 1, 32'h99,   0, 0,   1, 0, 32'h5A,   0, 1, 1);
        tbl[8]  = mk(0, 1, 32'h22,   0, 0,   0, 0, 32'h5A,   0, 1, 1);
        tbl[9]  = mk(0, 0, 32'h0,    0, 0,   1, 0, 32'h5A,   0, 1, 2);
        tbl[10] = mk(0, 1, 32'h33,   0, 0,   0, 0, 32'h5A,   0, 1, 2);
        tbl[11] = mk(0, 0, 32'h0,    0, 0,   1, 0, 32'h5A,   0, 1, 3);
        tbl[12] = mk(0, 1, 32'h44,   0, 0,   0, 0, 32'h5A,   0, 1, 3);
        tbl[13] = mk(0, 1, 32'h77,   1, 0,   0, 1, 32'h44,   0, 2, 3);
        tbl[14] = mk(0, 0, 32'h0,    0, 1,   1, 0, 32'h44,   0, 2, 3);

        for (int i = 0; i < 15; i++) begin
            drive(tbl[i].r, tbl[i].cv, tbl[i].cd, tbl[i].sx, tbl[i].ordy);
            chk($sformatf("tbl%0d_rdy", i), 64'(cr[0]), 64'(tbl[i].e_rdy));
            chk($sformatf("tbl%0d_vld", i), 64'(ov[0]), 64'(tbl[i].e_vld));
            chk($sformatf("tbl%0d_data", i), 64'(od[0]), 64'(tbl[i].e_data));
            chk($sformatf("tbl%0d_fail", i), 64'(of[0]), 64'(tbl[i].e_fail));
            chk($sformatf("tbl%0d_acc", i), 64'(acc_a), STATS ? 64'(tbl[i].e_acc) : 64'd0);
            chk($sformatf("tbl%0d_rej", i), 64'(rej_a), STATS ? 64'(tbl[i].e_rej) : 64'd0);
        end

        // Backpressure: result held for 10 cycles, then one cycle back to IDLE
        drive(0, 1, 32'hCAFE0001, 0, 0);
        drive(0, 0, 32'h0, 1, 0);
        for (int i = 0; i < 10; i++) begin
            drive(0, 1, $urandom, 1'($urandom_range(0, 1)), 0);
            chk("bp_vld", 64'(ov[0]), 64'd1);
            chk("bp_data", 64'(od[0]), 64'hCAFE0001);
            chk("bp_fail", 64'(of[0]), 64'd0);
            chk("bp_rdy", 64'(cr[0]), 64'd0);
        end
        drive(0, 0, 32'h0, 0, 1);
        chk("bp_rel_rdy", 64'(cr[0]), 64'd1);
        chk("bp_rel_vld", 64'(ov[0]), 64'd0);

        // Reset while a candidate is in EVAL with a satisfying split_x
        drive(0, 1, 32'hBEEF0002, 0, 0);
        chk("rst_pre_bus", 64'(sb[0]), 64'hBEEF0002);
        drive(1, 0, 32'h0, 1, 1);
        chk("rst_rdy", 64'(cr[0]), 64'd0);
        chk("rst_vld", 64'(ov[0]), 64'd0);
        chk("rst_data", 64'(od[0]), 64'd0);
        chk("rst_bus", 64'(sb[0]), 64'd0);
        chk("rst_acc", 64'(acc_a), 64'd0);
        chk("rst_rej", 64'(rej_a), 64'd0);
        drive(0, 0, 32'h0, 1, 1);
        chk("rst_after_vld", 64'(ov[0]), 64'd0);
        chk("rst_after_rdy", 64'(cr[0]), 64'd1);

        // Exhaustion: dut_b fails on its 4th reject, dut_c on its 1st
        d0 = 32'hD000_0000;
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, d0 + DW'(i), 0, 0);
            drive(0, 0, 32'h0, 0, 0);
            if (i == 0) begin
                chk("mt1_vld", 64'(ov[2]), 64'd1);
                chk("mt1_fail", 64'(of[2]), 64'd1);
                chk("mt1_data", 64'(od[2]), 64'(d0));
            end
            if (i == 2) chk("ex_b_early", 64'(ov[1]), 64'd0);
        end
        chk("ex_b_vld", 64'(ov[1]), 64'd1);
        chk("ex_b_fail", 64'(of[1]), 64'd1);
        chk("ex_b_data", 64'(od[1]), 64'(d0 + 32'd3));
        drive(0, 0, 32'h0, 0, 1);
        d0 = 32'hD100_0000;
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, d0 + DW'(i), 0, 0);
            drive(0, 0, 32'h0, 0, 0);
            if (i == 2) chk("ex2_b_early", 64'(ov[1]), 64'd0);
        end
        chk("ex2_b_vld", 64'(ov[1]), 64'd1);
        chk("ex2_b_fail", 64'(of[1]), 64'd1);
        chk("ex2_b_data", 64'(od[1]), 64'(d0 + 32'd3));
        drive(0, 0, 32'h0, 0, 1);

        // Saturation: five accepts into a 2-bit counter
        for (int i = 0; i < 5; i++) begin
            drive(0, 1, 32'hE000_0000 + DW'(i), 0, 1);
            drive(0, 0, 32'h0, 1, 1);
            chk("sat_vld", 64'(ov[1]), 64'd1);
            drive(0, 0, 32'h0, 0, 1);
        end
        chk("sat_acc_b", 64'(acc_b), STATS ? 64'd3 : 64'd0);
        chk("sat_acc_c", 64'(acc_c), STATS ? 64'd5 : 64'd0);

        // Randomized traffic with occasional resets
        drive(1, 0, 32'h0, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) < 7), $urandom,
                  1'($urandom_range(0, 1)), ($urandom_range(0, 9) < 6));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
